gpio_bank: RTL



---
 rtl/gpio_bank.sv | 116 +++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO bank with per-pin direction,
// input synchroniser and edge-detect interrupts (W1C pending).
module gpio_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_MODE   = 0,
  parameter logic [WIDTH-1:0] RST_OUT     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [3:0]       waddr,
  input  logic [31:0]      wdata,
  input  logic             ren,
  input  logic [3:0]       raddr,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] phyin,
  output logic [WIDTH-1:0] phyout,
  output logic [WIDTH-1:0] phyoe,
  output logic             irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_w;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       arm_q, arm_d;

  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] w1c;
  logic             armed;
  logic             unused_bits;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign wval  = wdata[WIDTH-1:0];
  assign armed = (arm_q == ARM_MAX);

  assign unused_bits = ^{waddr[1:0], raddr[1:0], wdata};

  always_comb begin
    if (EDGE_MODE == 0)
      edge_w = sync & ~prev_q;
    else if (EDGE_MODE == 1)
      edge_w = ~sync & prev_q;
    else
      edge_w = sync ^ prev_q;
  end

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    ien_d = ien_q;
    w1c   = '0;
    if (wen) begin
      unique case (waddr[3:2])
        2'd0: out_d = wval;
        2'd1: dir_d = wval;
        2'd2: ien_d = wval;
        2'd3: w1c   = wval;
        default: ;
      endcase
    end
    // an edge in the same cycle as a clear must win
    pend_d = (pend_q & ~w1c) | (armed ? edge_w : '0);
    arm_d  = armed ? arm_q : arm_q + 3'd1;
  end

  always_comb begin
    rdata_d = '0;
    if (ren) begin
      unique case (raddr[3:2])
        2'd0: rdata_d[WIDTH-1:0] = sync;
        2'd1: rdata_d[WIDTH-1:0] = dir_q;
        2'd2: rdata_d[WIDTH-1:0] = ien_q;
        2'd3: rdata_d[WIDTH-1:0] = pend_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      out_q   <= RST_OUT;
      dir_q   <= '0;
      ien_q   <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
      arm_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], phyin};
      prev_q  <= sync;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign rdata  = rdata_q;
  assign phyout = out_q;
  assign phyoe  = dir_q;
  assign irq    = |(pend_q & ien_q);

endmodule
